sha256_padder: RTL and testbench

//  Upstream stage of the SHA256 accelerator. It turns a 32-bit word stream of

---
 rtl/sha256_padder_if.sv | 24 ++
 rtl/sha256_padder.sv | 163 ++++++++++++++++
 tb/tb_sha256_padder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_padder_if.sv
// Word-stream input and padded-block output of the SHA256 padder, grouped as one bundle.
// The master drives message words and takes blocks; the slave is the padder.
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a big-endian 32-bit word stream into 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_padder #(
  parameter int BYTE_CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  sha256_padder_if.slave bus,
  output logic           busy
);

  typedef enum logic [2:0] {S_FILL, S_PAD, S_ZERO, S_LEN, S_EMIT} state_t;

  state_t                state_q, state_d;
  state_t                ret_q, ret_d;
  logic [3:0]            widx_q, widx_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0][31:0]     buf_q, buf_d;
  logic                  first_q, first_d;
  logic                  in_ready_q, in_ready_d;
  logic                  blk_valid_q, blk_valid_d;
  logic                  blk_first_q, blk_first_d;
  logic                  blk_last_q, blk_last_d;
  logic                  busy_q, busy_d;

  // Working values for the word-advance step shared by FILL, PAD and ZERO.
  state_t                after_s;
  logic                  advance;
  logic                  full_word;
  logic [2:0]            add_bytes;
  logic [31:0]           tail_word;
  logic [63:0]           len_bits;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d     = state_q;
    ret_d       = ret_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    first_d     = first_q;
    blk_valid_d = blk_valid_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;
    busy_d      = busy_q;
    after_s     = S_FILL;
    advance     = 1'b0;
    full_word   = !bus.in_last || (bus.in_nbytes >= 3'd4);
    add_bytes   = full_word ? 3'd4 : bus.in_nbytes;
    len_bits    = 64'(cnt_q) << 3;

    unique case (bus.in_nbytes)
      3'd0:    tail_word = 32'h8000_0000;
      3'd1:    tail_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    tail_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    tail_word = {bus.in_data[31:8], 8'h80};
      default: tail_word = bus.in_data;
    endcase

    unique case (state_q)
      S_FILL: begin
        if (bus.in_valid && in_ready_q) begin
          busy_d         = 1'b1;
          cnt_d          = cnt_q + BYTE_CNT_W'(add_bytes);
          buf_d[widx_q]  = full_word ? bus.in_data : tail_word;
          after_s        = !bus.in_last ? S_FILL : (full_word ? S_PAD : S_ZERO);
          advance        = 1'b1;
        end
      end
      S_PAD: begin
        buf_d[widx_q] = 32'h8000_0000;
        after_s       = S_ZERO;
        advance       = 1'b1;
      end
      S_ZERO: begin
        buf_d[widx_q] = 32'h0;
        after_s       = S_ZERO;
        advance       = 1'b1;
      end
      S_LEN: begin
        buf_d[14]   = len_bits[63:32];
        buf_d[15]   = len_bits[31:0];
        state_d     = S_EMIT;
        blk_valid_d = 1'b1;
        blk_first_d = first_q;
        blk_last_d  = 1'b1;
      end
      S_EMIT: begin
        if (bus.blk_ready) begin
          blk_valid_d = 1'b0;
          blk_first_d = 1'b0;
          blk_last_d  = 1'b0;
          widx_d      = 4'd0;
          buf_d       = '0;
          first_d     = 1'b0;
          state_d     = ret_q;
          if (blk_last_q) begin
            state_d = S_FILL;
            cnt_d   = '0;
            busy_d  = 1'b0;
            first_d = 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    // A full buffer is emitted before continuing; the length words always land in 14/15.
    if (advance) begin
      widx_d = widx_q + 4'd1;
      if (widx_q == 4'd15) begin
        state_d     = S_EMIT;
        ret_d       = after_s;
        blk_valid_d = 1'b1;
        blk_first_d = first_q;
        blk_last_d  = 1'b0;
      end else if (after_s == S_ZERO && widx_d == 4'd14) begin
        state_d = S_LEN;
      end else begin
        state_d = after_s;
      end
    end

    in_ready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FILL;
      ret_q       <= S_FILL;
      widx_q      <= 4'd0;
      cnt_q       <= '0;
      // NOTE: the block buffer is reset because it drives blk_data, which must read zero.
      buf_q       <= '0;
      first_q     <= 1'b1;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      widx_q      <= widx_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = buf_q;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last  = blk_last_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: a byte-level FIPS 180-4 padding model predicts every
// block, and a monitor compares each block handshake against the predicted queue.
module tb_sha256_padder;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  logic clk;
  logic reset;
  logic busy;

  sha256_padder_if bus_if ();

  sha256_padder #(.BYTE_CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .busy  (busy)
  );

  int          checks;
  int          errors;
  int          hs_count;
  int          ready_mode;
  blk_t        exp_q[$];
  logic [7:0]  msg_q[$];
  logic        hold_pending;
  blk_t        held;
  blk_t        exp_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pad the byte message per FIPS 180-4 and split into 64-byte blocks.
  task automatic push_expected();
    logic [7:0]      p[$];
    longint unsigned bits;
    int              nblk;
    blk_t            b;
    p = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      for (int w = 0; w < 16; w++)
        b.data[32*w +: 32] = {p[k*64 + 4*w], p[k*64 + 4*w + 1],
                              p[k*64 + 4*w + 2], p[k*64 + 4*w + 3]};
      b.first = (k == 0);
      b.last  = (k == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called between a rising edge and the following falling edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = d;
    bus_if.in_last   = last;
    bus_if.in_nbytes = nb;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus_if.in_ready && t < 2000);
    check("in_accept_ready", 512'(bus_if.in_ready), 512'(1));
    if (!bus_if.in_ready) begin
      bus_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 32'($urandom);
  endtask

  task automatic send_msg();
    int          len;
    int          nw;
    int          rem;
    logic [31:0] d;
    logic        last;
    logic [2:0]  nb;
    len = msg_q.size();
    push_expected();
    nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      for (int b = 0; b < 4; b++)
        if (w*4 + b < len) d[31 - 8*b -: 8] = msg_q[w*4 + b];
      last = (w == nw - 1);
      rem  = len - w*4;
      nb   = last ? ((rem >= 4) ? 3'd4 : 3'(rem)) : 3'($urandom_range(0, 4));
      send_word(d, last, nb);
      if (w == 0) check("busy_after_first_word", 512'(busy), 512'(1));
    end
  endtask

  task automatic random_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 512'(exp_q.size()), 512'(0));
    repeat (2) @(negedge clk);
    check("busy_idle", 512'(busy), 512'(0));
    check("in_ready_idle", 512'(bus_if.in_ready), 512'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 512'(bus_if.in_ready), 512'(0));
    check("rst_blk_valid", 512'(bus_if.blk_valid), 512'(0));
    check("rst_blk_first", 512'(bus_if.blk_first), 512'(0));
    check("rst_blk_last", 512'(bus_if.blk_last), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_blk_data", bus_if.blk_data, 512'(0));
  endtask

  // blk_ready driver: random, forced low, or forced high.
  initial begin
    bus_if.blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus_if.blk_ready = 1'b0;
        2:       bus_if.blk_ready = 1'b1;
        default: bus_if.blk_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares every block handshake and checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else if (bus_if.blk_valid) begin
      check("in_ready_low_in_emit", 512'(bus_if.in_ready), 512'(0));
      if (hold_pending) begin
        check("hold_blk_data", bus_if.blk_data, held.data);
        check("hold_blk_first", 512'(bus_if.blk_first), 512'(held.first));
        check("hold_blk_last", 512'(bus_if.blk_last), 512'(held.last));
      end
      if (bus_if.blk_ready) begin
        check("block_expected", 512'(exp_q.size() != 0), 512'(1));
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("blk_data", bus_if.blk_data, exp_b.data);
          check("blk_first", 512'(bus_if.blk_first), 512'(exp_b.first));
          check("blk_last", 512'(bus_if.blk_last), 512'(exp_b.last));
        end
        hs_count++;
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held.data    = bus_if.blk_data;
        held.first   = bus_if.blk_first;
        held.last    = bus_if.blk_last;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    int t;
    int hs0;
    int len;
    checks           = 0;
    errors           = 0;
    hs_count         = 0;
    ready_mode       = 0;
    hold_pending     = 1'b0;
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 32'h0;
    bus_if.in_last   = 1'b0;
    bus_if.in_nbytes = 3'd0;

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_before_first_edge", 512'(bus_if.in_ready), 512'(0));
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 512'(bus_if.in_ready), 512'(1));

    // Directed messages: "abc", empty, 56 bytes, 64 bytes.
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    msg_q.delete();
    send_msg();
    random_msg(56);
    send_msg();
    random_msg(64);
    send_msg();
    wait_drain();

    // Backpressure: stall the block for 10 cycles, then release with ready held high.
    ready_mode = 1;
    @(posedge clk);
    #1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    t = 0;
    while (!bus_if.blk_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    hs0 = hs_count;
    repeat (10) begin
      @(negedge clk);
      check("bp_blk_valid_held", 512'(bus_if.blk_valid), 512'(1));
      check("bp_in_ready_low", 512'(bus_if.in_ready), 512'(0));
    end
    ready_mode = 2;
    t = 0;
    while (hs_count == hs0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("bp_single_handshake", 512'(hs_count - hs0), 512'(1));
    ready_mode = 0;
    wait_drain();

    // Reset while the padder is zero-filling, then a clean "abc".
    random_msg(5);
    send_msg();
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    wait_drain();

    // Random messages biased towards short lengths and the 52..68 byte boundary region.
    for (int m = 0; m < 20; m++) begin
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(0, 8);
        1:       len = $urandom_range(52, 68);
        default: len = $urandom_range(0, 200);
      endcase
      random_msg(len);
      send_msg();
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
